// File: rtl/tdm_voice_sequencer_pkg.sv
// Shared parameters and FSM encoding for the TDM voice sequencer.
package synth_tdm_pkg;

  localparam int unsigned D_W          = 16;
  localparam int unsigned VOICES       = 8;
  localparam int unsigned VOICES_BITS  = 3;
  localparam int unsigned PHASE_W      = 24;
  localparam int unsigned ADDR_W       = 8;
  localparam int unsigned ACC_W        = D_W + VOICES_BITS;
  localparam int unsigned RESP_TIMEOUT = 15;
  localparam int unsigned WCNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/tdm_voice_sequencer_if.sv
// Wavetable request/response interface between the sequencer and the wavetable.
interface tdm_voice_sequencer_if;
  import synth_tdm_pkg::*;

  logic [1:0]        selected_wave;
  logic [ADDR_W-1:0] nco_addr_out;
  logic              addr_valid;
  logic [D_W-1:0]    sample_in;
  logic              sample_valid;

  modport master (
    output selected_wave, nco_addr_out, addr_valid,
    input  sample_in, sample_valid
  );

  modport slave (
    input  selected_wave, nco_addr_out, addr_valid,
    output sample_in, sample_valid
  );
endinterface

// File: rtl/tdm_voice_sequencer_nco_phase_bank.sv
// Per-voice tuning words and free-running phase accumulators.
module nco_phase_bank
  import synth_tdm_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tune_we,
  input  logic [VOICES_BITS-1:0] tune_voice,
  input  logic [PHASE_W-1:0]     tune_word,
  input  logic                   advance,
  input  logic [VOICES_BITS-1:0] idx,
  output logic [PHASE_W-1:0]     phase_c
);

  logic [PHASE_W-1:0] tune_q  [VOICES];
  logic [PHASE_W-1:0] phase_q [VOICES];

  // A tune write to the voice being advanced lands after this cycle's add.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < VOICES; i++) begin
        tune_q[i]  <= '0;
        phase_q[i] <= '0;
      end
    end else begin
      if (tune_we) tune_q[tune_voice] <= tune_word;
      if (advance) phase_q[idx] <= phase_q[idx] + tune_q[idx];
    end
  end

  assign phase_c = phase_q[idx];

endmodule

// File: rtl/tdm_voice_sequencer.sv
// Walks all voices once per frame tick, fetches one sample each and emits the averaged mix.
module tdm_voice_sequencer
  import synth_tdm_pkg::*;
(
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   frame_tick,
  input  logic                   tune_we,
  input  logic [VOICES_BITS-1:0] tune_voice,
  input  logic [PHASE_W-1:0]     tune_word,
  input  logic [VOICES-1:0]      voice_gate,
  input  logic [2*VOICES-1:0]    voice_wave,
  tdm_voice_sequencer_if.master  wt,
  output logic [D_W-1:0]         mix_out,
  output logic                   mix_valid,
  output logic                   busy,
  output logic                   overrun,
  output logic                   resp_fault
);

  localparam logic [VOICES_BITS-1:0] LAST_IDX = VOICES_BITS'(VOICES - 1);
  localparam logic [WCNT_W-1:0]      WCNT_MAX = WCNT_W'(RESP_TIMEOUT - 1);

  seq_state_e               state_q, state_nxt;
  logic [VOICES_BITS-1:0]   idx_q, idx_nxt;
  logic signed [ACC_W-1:0]  acc_q, acc_nxt;
  logic [WCNT_W-1:0]        wcnt_q, wcnt_nxt;
  logic [ADDR_W-1:0]        addr_q, addr_nxt;
  logic [1:0]               wave_q, wave_nxt;
  logic                     addr_valid_nxt;
  logic [D_W-1:0]           mix_q, mix_nxt;
  logic                     mix_valid_nxt;
  logic                     overrun_nxt, fault_nxt;
  logic                     advance_c, next_voice_c;
  logic [PHASE_W-1:0]       phase_c;
  logic signed [ACC_W-1:0]  sample_ext_c;

  nco_phase_bank u_bank (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .tune_we    (tune_we),
    .tune_voice (tune_voice),
    .tune_word  (tune_word),
    .advance    (advance_c),
    .idx        (idx_q),
    .phase_c    (phase_c)
  );

  assign sample_ext_c = {{VOICES_BITS{wt.sample_in[D_W-1]}}, wt.sample_in};

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state_q;
    idx_nxt        = idx_q;
    acc_nxt        = acc_q;
    wcnt_nxt       = wcnt_q;
    addr_nxt       = addr_q;
    wave_nxt       = wave_q;
    addr_valid_nxt = 1'b0;
    mix_nxt        = mix_q;
    mix_valid_nxt  = 1'b0;
    overrun_nxt    = overrun | (frame_tick && (state_q != IDLE));
    fault_nxt      = resp_fault;
    advance_c      = 1'b0;
    next_voice_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          idx_nxt   = '0;
          acc_nxt   = '0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        advance_c = 1'b1;
        if (voice_gate[idx_q]) begin
          addr_nxt       = phase_c[PHASE_W-1 -: ADDR_W];
          wave_nxt       = voice_wave[{idx_q, 1'b0} +: 2];
          addr_valid_nxt = 1'b1;
          wcnt_nxt       = '0;
          state_nxt      = WAIT;
        end else begin
          next_voice_c = 1'b1;
        end
      end
      WAIT: begin
        if (wt.sample_valid) begin
          acc_nxt      = acc_q + sample_ext_c;
          next_voice_c = 1'b1;
        end else if (wcnt_q == WCNT_MAX) begin
          fault_nxt    = 1'b1;
          next_voice_c = 1'b1;
        end else begin
          wcnt_nxt = wcnt_q + 1'b1;
        end
      end
      DONE: begin
        mix_nxt       = acc_q[ACC_W-1:VOICES_BITS];
        mix_valid_nxt = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (next_voice_c) begin
      if (idx_q == LAST_IDX) begin
        state_nxt = DONE;
      end else begin
        idx_nxt   = idx_q + 1'b1;
        state_nxt = ISSUE;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      acc_q          <= '0;
      wcnt_q         <= '0;
      addr_q         <= '0;
      wave_q         <= '0;
      wt.addr_valid  <= 1'b0;
      mix_q          <= '0;
      mix_valid      <= 1'b0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
      resp_fault     <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      idx_q          <= idx_nxt;
      acc_q          <= acc_nxt;
      wcnt_q         <= wcnt_nxt;
      addr_q         <= addr_nxt;
      wave_q         <= wave_nxt;
      wt.addr_valid  <= addr_valid_nxt;
      mix_q          <= mix_nxt;
      mix_valid      <= mix_valid_nxt;
      busy           <= (state_nxt != IDLE);
      overrun        <= overrun_nxt;
      resp_fault     <= fault_nxt;
    end
  end

  assign wt.nco_addr_out  = addr_q;
  assign wt.selected_wave = wave_q;
  assign mix_out          = mix_q;

endmodule
